// File: rtl/fetch_pkg.sv
// Shared definitions for the dual-issue instruction fetch front end:
// FSM state encoding, queue entry layout, PC step constants and helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } fetch_state_e;

  // One queue entry: instruction word plus the PC it was fetched from.
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } q_entry_t;

  localparam logic [31:0] PC_INC       = 32'd8;
  localparam logic [31:0] SLOT_OFS     = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Saturating increment used by the optional performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Dual-push / dual-pop circular instruction queue with synchronous flush.
// Pushes always carry a full pair; pops are clamped to the current occupancy.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 8,
  parameter int QAW    = 3
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           flush,
  input  logic           push,
  input  q_entry_t       push_e0,
  input  q_entry_t       push_e1,
  input  logic [1:0]     pop,
  output q_entry_t       head_e0,
  output q_entry_t       head_e1,
  output logic           head_v0,
  output logic           head_v1,
  output logic [QAW:0]   count
);

  localparam logic [QAW-1:0] PTR_ONE = {{(QAW-1){1'b0}}, 1'b1};
  localparam logic [QAW:0]   CNT_TWO = {{(QAW-1){1'b0}}, 2'b10};
  localparam logic [QAW:0]   CNT_ZERO = {(QAW+1){1'b0}};

  q_entry_t          mem_r [QDEPTH];
  logic [QAW-1:0]    head_r;
  logic [QAW-1:0]    tail_r;
  logic [QAW:0]      count_r;
  logic [QAW:0]      pop_req_s;
  logic [QAW:0]      pop_eff_s;
  logic [QAW:0]      push_cnt_s;

  // Clamp the requested pop count to what is actually stored.
  always_comb begin
    pop_req_s = {{(QAW-1){1'b0}}, pop};
    if (pop_req_s > count_r) begin
      pop_eff_s = count_r;
    end else begin
      pop_eff_s = pop_req_s;
    end
    if (push) begin
      push_cnt_s = CNT_TWO;
    end else begin
      push_cnt_s = CNT_ZERO;
    end
  end

  // Storage: both words of a pair are written together at the tail.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[tail_r]           <= push_e0;
      mem_r[tail_r + PTR_ONE] <= push_e1;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head_r  <= {QAW{1'b0}};
      tail_r  <= {QAW{1'b0}};
      count_r <= CNT_ZERO;
    end else if (flush) begin
      head_r  <= {QAW{1'b0}};
      tail_r  <= {QAW{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      head_r  <= head_r + pop_eff_s[QAW-1:0];
      tail_r  <= push ? (tail_r + PTR_ONE + PTR_ONE) : tail_r;
      count_r <= count_r + push_cnt_s - pop_eff_s;
    end
  end

  assign head_e0 = mem_r[head_r];
  assign head_e1 = mem_r[head_r + PTR_ONE];
  assign head_v0 = (count_r != CNT_ZERO);
  assign head_v1 = (count_r >= CNT_TWO);
  assign count   = count_r;

endmodule

// File: rtl/inst_fetch_unit.sv
// Dual-issue instruction fetch unit: drives two consecutive fetch addresses,
// captures the cache pair into an in-order queue and handles stalls,
// back-pressure and redirects.
// Optional build macro FETCH_PERF_EN adds saturating WAIT/FULL/redirect
// performance counters as extra output ports.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 8,
  parameter int          QAW      = 3
) (
  input  logic           clk,
  input  logic           clrn,
  output logic [31:0]    pc1,
  output logic [31:0]    pc2,
  input  logic [31:0]    inst1,
  input  logic [31:0]    inst2,
  input  logic           inst_valid,
  input  logic           redirect,
  input  logic [31:0]    redirect_pc,
  input  logic [1:0]     deq,
  output logic           out_valid1,
  output logic [31:0]    out_inst1,
  output logic [31:0]    out_pc1,
  output logic           out_valid2,
  output logic [31:0]    out_inst2,
  output logic [31:0]    out_pc2,
  output logic [QAW:0]   q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]    perf_wait_cyc,
  output logic [31:0]    perf_full_cyc,
  output logic [31:0]    perf_redirects
`endif
);

  localparam logic [QAW:0] DEPTH_C = (QAW+1)'(QDEPTH);
  localparam logic [QAW:0] TWO_C   = {{(QAW-1){1'b0}}, 2'b10};

  fetch_state_e   state_r;
  fetch_state_e   state_nx_s;
  logic [31:0]    pc_r;
  logic [31:0]    pc2_r;
  logic [31:0]    pc_nx_s;
  logic           enq_s;
  logic           flush_s;
  logic           room_s;
  logic [QAW:0]   count_s;
  logic [QAW:0]   free_s;
  logic [1:0]     pop_s;
  q_entry_t       push_e0_s;
  q_entry_t       push_e1_s;
  q_entry_t       head_e0_s;
  q_entry_t       head_e1_s;

  // Free slots are judged on occupancy before this cycle's dequeue.
  assign free_s = DEPTH_C - count_s;
  assign room_s = (free_s >= TWO_C);

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; a redirect always restarts in RUN.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: state_nx_s = ST_RUN;
      ST_RUN: begin
        if (redirect) begin
          state_nx_s = ST_RUN;
        end else if (!inst_valid) begin
          state_nx_s = ST_WAIT;
        end else if (!room_s) begin
          state_nx_s = ST_FULL;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          state_nx_s = ST_RUN;
        end else if (inst_valid && room_s) begin
          state_nx_s = ST_RUN;
        end else if (inst_valid) begin
          state_nx_s = ST_FULL;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_FULL: begin
        if (redirect || room_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_FULL;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs: enqueue strobe and queue flush.
  always_comb begin
    enq_s   = 1'b0;
    flush_s = 1'b0;
    case (state_r)
      ST_RUN, ST_WAIT: begin
        flush_s = redirect;
        enq_s   = !redirect && inst_valid && room_s;
      end
      ST_FULL: begin
        flush_s = redirect;
        enq_s   = 1'b0;
      end
      default: begin
        flush_s = 1'b0;
        enq_s   = 1'b0;
      end
    endcase
  end

  // Next fetch address: redirect target, next pair, or hold.
  always_comb begin
    if (flush_s) begin
      pc_nx_s = align_pc(redirect_pc);
    end else if (enq_s) begin
      pc_nx_s = pc_r + PC_INC;
    end else begin
      pc_nx_s = pc_r;
    end
  end

  // Fetch PC registers; slot 1 address is kept registered alongside slot 0.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_r  <= RESET_PC;
      pc2_r <= RESET_PC + SLOT_OFS;
    end else begin
      pc_r  <= pc_nx_s;
      pc2_r <= pc_nx_s + SLOT_OFS;
    end
  end

  assign pc1 = pc_r;
  assign pc2 = pc2_r;

  assign push_e0_s = '{inst: inst1, pc: pc_r};
  assign push_e1_s = '{inst: inst2, pc: pc2_r};
  assign pop_s     = flush_s ? 2'b00 : deq;

  inst_queue #(
    .QDEPTH (QDEPTH),
    .QAW    (QAW)
  ) u_queue (
    .clk     (clk),
    .clrn    (clrn),
    .flush   (flush_s),
    .push    (enq_s),
    .push_e0 (push_e0_s),
    .push_e1 (push_e1_s),
    .pop     (pop_s),
    .head_e0 (head_e0_s),
    .head_e1 (head_e1_s),
    .head_v0 (out_valid1),
    .head_v1 (out_valid2),
    .count   (count_s)
  );

  assign out_inst1 = head_e0_s.inst;
  assign out_pc1   = head_e0_s.pc;
  assign out_inst2 = head_e1_s.inst;
  assign out_pc2   = head_e1_s.pc;
  assign q_count   = count_s;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_wait_r;
  logic [31:0] perf_full_r;
  logic [31:0] perf_redir_r;

  // Saturating stall/redirect counters, cleared only by the hard reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perf_wait_r  <= 32'd0;
      perf_full_r  <= 32'd0;
      perf_redir_r <= 32'd0;
    end else begin
      perf_wait_r  <= (state_r == ST_WAIT) ? sat_inc32(perf_wait_r) : perf_wait_r;
      perf_full_r  <= (state_r == ST_FULL) ? sat_inc32(perf_full_r) : perf_full_r;
      perf_redir_r <= flush_s ? sat_inc32(perf_redir_r) : perf_redir_r;
    end
  end

  assign perf_wait_cyc  = perf_wait_r;
  assign perf_full_cyc  = perf_full_r;
  assign perf_redirects = perf_redir_r;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a queue-based reference model is
// compared against the DUT on every falling edge, plus directed literal checks.
module tb_inst_fetch_unit;

  localparam int QDEPTH = 8;
  localparam int QAW    = 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_FULL = 3;

  logic         clk = 1'b0;
  logic         clrn = 1'b1;
  logic [31:0]  pc1, pc2, inst1, inst2;
  logic         inst_valid;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [1:0]   deq;
  logic         out_valid1, out_valid2;
  logic [31:0]  out_inst1, out_pc1, out_inst2, out_pc2;
  logic [QAW:0] q_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] cache_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign inst1 = cache_word(pc1);
  assign inst2 = cache_word(pc2);

  inst_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (QDEPTH),
    .QAW      (QAW)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .pc1         (pc1),
    .pc2         (pc2),
    .inst1       (inst1),
    .inst2       (inst2),
    .inst_valid  (inst_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .out_valid1  (out_valid1),
    .out_inst1   (out_inst1),
    .out_pc1     (out_pc1),
    .out_valid2  (out_valid2),
    .out_inst2   (out_inst2),
    .out_pc2     (out_pc2),
    .q_count     (q_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the queue is a plain list of {inst, pc} words.
  logic [63:0] mq [$];
  logic [31:0] mpc  = 32'h0000_0000;
  int          mmode = M_IDLE;

  always @(posedge clk or negedge clrn) begin
    int  free_m;
    int  npop;
    bit  enq_m;
    if (!clrn) begin
      mq.delete();
      mpc   = 32'h0000_0000;
      mmode = M_IDLE;
    end else if (mmode == M_IDLE) begin
      mmode = M_RUN;
    end else if (redirect) begin
      mq.delete();
      mpc   = {redirect_pc[31:2], 2'b00};
      mmode = M_RUN;
    end else begin
      free_m = QDEPTH - mq.size();
      enq_m  = (mmode == M_RUN || mmode == M_WAIT) && inst_valid && (free_m >= 2);
      npop   = (int'(deq) > mq.size()) ? mq.size() : int'(deq);
      for (int k = 0; k < npop; k++) begin
        void'(mq.pop_front());
      end
      if (enq_m) begin
        mq.push_back({cache_word(mpc), mpc});
        mq.push_back({cache_word(mpc + 32'd4), mpc + 32'd4});
        mpc = mpc + 32'd8;
      end
      case (mmode)
        M_RUN:   mmode = !inst_valid ? M_WAIT : ((free_m < 2) ? M_FULL : M_RUN);
        M_WAIT:  mmode = enq_m ? M_RUN : (inst_valid ? M_FULL : M_WAIT);
        M_FULL:  mmode = (free_m >= 2) ? M_RUN : M_FULL;
        default: mmode = M_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("pc1", pc1, mpc);
    chk("pc2", pc2, mpc + 32'd4);
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("out_valid1", 32'(out_valid1), 32'(mq.size() >= 1));
    chk("out_valid2", 32'(out_valid2), 32'(mq.size() >= 2));
    if (mq.size() >= 1) begin
      chk("out_inst1", out_inst1, mq[0][63:32]);
      chk("out_pc1", out_pc1, mq[0][31:0]);
    end
    if (mq.size() >= 2) begin
      chk("out_inst2", out_inst2, mq[1][63:32]);
      chk("out_pc2", out_pc2, mq[1][31:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    inst_valid  = 1'b1;
    deq         = 2'd0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;

    // Reset state
    #1 clrn = 1'b0;
    #2;
    chk("rst_pc1", pc1, 32'h0000_0000);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    cyc(2);
    clrn = 1'b1;

    // Fill: IDLE cycle, then pairs at 0,8,16,24, then FULL holding 32
    cyc(6);
    chk("fill_pc1", pc1, 32'h0000_0020);
    chk("fill_count", 32'(q_count), 32'd8);
    chk("fill_out_pc1", out_pc1, 32'h0000_0000);
    chk("fill_out_pc2", out_pc2, 32'h0000_0004);

    // One deq of 2 from full
    deq = 2'd2;
    cyc(1);
    deq = 2'd0;
    chk("deq_count", 32'(q_count), 32'd6);
    chk("deq_out_pc1", out_pc1, 32'h0000_0008);
    cyc(1);
    chk("full_exit_pc1", pc1, 32'h0000_0020);
    cyc(1);
    chk("resume_pc1", pc1, 32'h0000_0028);
    chk("resume_count", 32'(q_count), 32'd8);

    // Drain with cache stalled, then hold in WAIT
    inst_valid = 1'b0;
    deq = 2'd2;
    cyc(3);
    deq = 2'd0;
    cyc(3);
    chk("wait_pc1", pc1, 32'h0000_0028);
    chk("wait_count", 32'(q_count), 32'd2);
    inst_valid = 1'b1;
    cyc(1);
    chk("wait_exit_pc1", pc1, 32'h0000_0030);
    chk("wait_exit_count", 32'(q_count), 32'd4);
    chk("wait_exit_out_pc1", out_pc1, 32'h0000_0020);

    // Redirect with simultaneous deq and valid fetch
    redirect = 1'b1;
    redirect_pc = 32'h0000_00E3;
    deq = 2'd2;
    cyc(1);
    redirect = 1'b0;
    deq = 2'd0;
    chk("redir_pc1", pc1, 32'h0000_00E0);
    chk("redir_count", 32'(q_count), 32'd0);
    chk("redir_valid1", 32'(out_valid1), 32'd0);
    cyc(1);
    chk("redir_out_pc1", out_pc1, 32'h0000_00E0);
    chk("redir_out_pc2", out_pc2, 32'h0000_00E4);

    // Over-dequeue clamps, with and without a same-cycle enqueue
    inst_valid = 1'b0;
    deq = 2'd1;
    cyc(1);
    deq = 2'd2;
    cyc(1);
    chk("clamp_count0", 32'(q_count), 32'd0);
    inst_valid = 1'b1;
    deq = 2'd0;
    cyc(1);
    inst_valid = 1'b0;
    deq = 2'd1;
    cyc(1);
    inst_valid = 1'b1;
    deq = 2'd2;
    cyc(1);
    chk("clamp_count2", 32'(q_count), 32'd2);
    chk("clamp_out_pc1", out_pc1, 32'h0000_00F0);

    // Pointer wrap with varied deq, stalls and occasional redirects
    for (int i = 0; i < 40; i++) begin
      deq         = 2'($urandom_range(0, 2));
      inst_valid  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      cyc(1);
    end

    // Asynchronous reset in the middle of enqueuing
    deq = 2'd0;
    redirect = 1'b0;
    inst_valid = 1'b1;
    cyc(2);
    @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("arst_count", 32'(q_count), 32'd0);
    chk("arst_valid1", 32'(out_valid1), 32'd0);
    chk("arst_valid2", 32'(out_valid2), 32'd0);
    chk("arst_pc1", pc1, 32'h0000_0000);
    cyc(1);
    clrn = 1'b1;
    cyc(1);
    chk("idle_pc1", pc1, 32'h0000_0000);
    chk("idle_count", 32'(q_count), 32'd0);
    cyc(1);
    chk("rerun_pc1", pc1, 32'h0000_0008);
    chk("rerun_out_pc1", out_pc1, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
